// File: rtl/clock_period_meter_pkg.sv
// Shared types and constants for the clock period meter and its helpers.
package clock_period_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2
   } meter_state_t;

   // All-ones value of a counter of the given width (capped at 64 bits).
   function automatic logic [63:0] count_max(input int unsigned width);
      if (width >= 64)
         return '1;
      return (64'd1 << width) - 64'd1;
   endfunction

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Synchronizes an asynchronous level into clock and flags its rising edges.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2   // must be at least 2
) (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   history;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q  <= '0;
         history <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
         history <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~history;

endmodule

// File: rtl/clock_period_meter.sv
// Measures the period of a slow asynchronous signal in system clock cycles.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no measurement in progress; rises only produce rise_tick
// ST_ARM     | waiting for the first rise that opens a period
// ST_MEASURE | counting clocks until the rise that closes the period
module clock_period_meter
   import clock_period_meter_pkg::*;
#(
   parameter int COUNT_WIDTH = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   sig_in,
   input  logic                   start,
   input  logic                   continuous,
   output logic                   rise_tick,
   output logic [COUNT_WIDTH-1:0] period,
   output logic                   period_valid,
   output logic                   busy,
   output logic                   overflow
);

   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(count_max(COUNT_WIDTH));
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

   meter_state_t           state, state_nxt;
   logic [COUNT_WIDTH-1:0] count;
   logic                   rise;
   logic                   cnt_sat;
   logic                   cnt_clr, cnt_load, cnt_inc;
   logic                   rpt, sat;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clock    (clock),
      .reset    (reset),
      .async_in (sig_in),
      .rise     (rise)
   );

   assign cnt_sat = (count == CNT_MAX);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // start wins over everything, including a coincident rise or saturation.
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = ST_ARM;
      end else begin
         case (state)
            ST_ARM: begin
               if (rise)
                  state_nxt = ST_MEASURE;
            end
            ST_MEASURE: begin
               if (rise) begin
                  if (!continuous)
                     state_nxt = ST_IDLE;
               end else if (cnt_sat) begin
                  state_nxt = ST_IDLE;
               end
            end
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      cnt_clr  = 1'b0;
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
      rpt      = 1'b0;
      sat      = 1'b0;
      busy     = (state != ST_IDLE);
      if (start) begin
         cnt_clr = 1'b1;
      end else begin
         case (state)
            ST_ARM: begin
               cnt_load = rise;
            end
            ST_MEASURE: begin
               if (rise) begin
                  rpt      = 1'b1;
                  cnt_load = 1'b1;
               end else if (cnt_sat) begin
                  sat = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count        <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         overflow     <= 1'b0;
         rise_tick    <= 1'b0;
      end else begin
         rise_tick    <= rise;
         period_valid <= rpt | sat;
         if (cnt_clr)
            count <= '0;
         else if (cnt_load)
            count <= CNT_ONE;
         else if (cnt_inc)
            count <= count + CNT_ONE;
         if (rpt)
            period <= count;
         else if (sat)
            period <= CNT_MAX;
         if (cnt_clr)
            overflow <= 1'b0;
         else if (sat)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomized bench for clock_period_meter: a 24-bit and a 4-bit instance against a timestamp model.
module tb_clock_period_meter;

   localparam int     S         = 2;
   localparam longint BIG_MAX   = (64'd1 << 24) - 1;
   localparam longint SMALL_MAX = 15;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        sig_in = 1'b0;
   logic        start = 1'b0;
   logic        continuous = 1'b0;
   logic        rt_b, pv_b, busy_b, ovf_b;
   logic [23:0] per_b;
   logic        rt_s, pv_s, busy_s, ovf_s;
   logic [3:0]  per_s;

   clock_period_meter #(.COUNT_WIDTH(24), .SYNC_STAGES(S)) dut_big (
      .clock(clock), .reset(reset), .sig_in(sig_in), .start(start), .continuous(continuous),
      .rise_tick(rt_b), .period(per_b), .period_valid(pv_b), .busy(busy_b), .overflow(ovf_b)
   );

   clock_period_meter #(.COUNT_WIDTH(4), .SYNC_STAGES(S)) dut_small (
      .clock(clock), .reset(reset), .sig_in(sig_in), .start(start), .continuous(continuous),
      .rise_tick(rt_s), .period(per_s), .period_valid(pv_s), .busy(busy_s), .overflow(ovf_s)
   );

   always #5 clock = ~clock;

   // Model keeps the cycle stamp of the opening rise; period = elapsed cycles.
   typedef struct {
      bit     armed;
      bit     meas;
      longint t0;
      bit     ovf;
      bit     valid;
      longint per;
      bit     rt;
   } mdl_t;

   mdl_t   mb, ms;
   int     checks = 0;
   int     failures = 0;
   longint cyc = 0;
   bit     sq[$];
   int     gen_per = 100;
   int     gen_ph = 0;
   int     vc_b, vc_s;
   longint last_b, last_s, first_b;
   bit     busy_at_valid_b;

   function automatic mdl_t step(input mdl_t m, input longint k, input bit st, input bit cont,
                                 input bit rise, input longint maxv);
      mdl_t   n;
      longint el;
      n = m;
      n.valid = 1'b0;
      n.rt = rise;
      if (st) begin
         n.armed = 1'b1;
         n.meas = 1'b0;
         n.ovf = 1'b0;
      end else if (m.armed && rise) begin
         n.armed = 1'b0;
         n.meas = 1'b1;
         n.t0 = k;
      end else if (m.meas) begin
         el = k - m.t0;
         if (rise) begin
            n.valid = 1'b1;
            n.per = el;
            if (cont) n.t0 = k;
            else n.meas = 1'b0;
         end else if (el >= maxv) begin
            n.valid = 1'b1;
            n.per = maxv;
            n.ovf = 1'b1;
            n.meas = 1'b0;
         end
      end
      return n;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic clear_stats();
      vc_b = 0; vc_s = 0; last_b = 0; last_s = 0; first_b = 0; busy_at_valid_b = 1'b1;
   endtask

   task automatic tick(input bit st);
      bit rise;
      start = st;
      sig_in = (gen_ph < gen_per / 2);
      gen_ph = (gen_ph + 1) % gen_per;
      @(posedge clock);
      #1;
      cyc++;
      if (!reset) begin
         sq.push_front(1'b0);
         mb = '{default: 0};
         ms = '{default: 0};
      end else begin
         sq.push_front(sig_in);
         rise = sq[S] & ~sq[S+1];
         mb = step(mb, cyc, st, continuous, rise, BIG_MAX);
         ms = step(ms, cyc, st, continuous, rise, SMALL_MAX);
      end
      void'(sq.pop_back());
      start = 1'b0;
      check("big_rise_tick", rt_b, mb.rt);
      check("big_valid", pv_b, mb.valid);
      check("big_period", per_b, mb.per);
      check("big_busy", busy_b, mb.armed | mb.meas);
      check("big_overflow", ovf_b, mb.ovf);
      check("small_rise_tick", rt_s, ms.rt);
      check("small_valid", pv_s, ms.valid);
      check("small_period", per_s, ms.per);
      check("small_busy", busy_s, ms.armed | ms.meas);
      check("small_overflow", ovf_s, ms.ovf);
      if (pv_b) begin
         vc_b++;
         last_b = per_b;
         if (vc_b == 1) first_b = per_b;
         busy_at_valid_b = busy_b;
      end
      if (pv_s) begin
         vc_s++;
         last_s = per_s;
      end
   endtask

   task automatic set_gen(input int p);
      gen_per = p;
      gen_ph = 0;
   endtask

   initial begin
      int n;
      int i;
      mb = '{default: 0};
      ms = '{default: 0};
      for (int j = 0; j < S + 2; j++) sq.push_back(1'b0);
      clear_stats();

      // Reset, then a 100-clock single-shot measurement.
      set_gen(100);
      for (int j = 0; j < 3; j++) tick(0);
      reset = 1'b1;
      for (int j = 0; j < 5; j++) tick(0);
      clear_stats();
      tick(1);
      for (int j = 0; j < 260; j++) tick(0);
      check("p1_report_count", vc_b, 1);
      check("p1_period", last_b, 100);
      check("p1_busy_at_valid", busy_at_valid_b, 0);
      check("p1_overflow", ovf_b, 0);
      check("p1_small_overflow", ovf_s, 1);
      check("p1_small_period", last_s, 15);

      // Divide-by-16 source, continuous mode.
      set_gen(16);
      continuous = 1'b1;
      clear_stats();
      tick(1);
      for (int j = 0; j < 12 * 16 + 20; j++) tick(0);
      check("p2_reports", vc_b >= 10, 1);
      check("p2_first", first_b, 16);
      check("p2_last", last_b, 16);

      // Saturation of the 4-bit instance, then start clears overflow.
      set_gen(40);
      continuous = 1'b0;
      clear_stats();
      tick(1);
      for (int j = 0; j < 100; j++) tick(0);
      check("p3_small_overflow", ovf_s, 1);
      check("p3_small_period", last_s, 15);
      check("p3_small_idle", busy_s, 0);
      check("p3_big_period", last_b, 40);
      tick(1);
      check("p3_overflow_cleared", ovf_s, 0);
      for (int j = 0; j < 20; j++) tick(0);

      // Restart during MEASURE when the counter is at 37.
      set_gen(100);
      continuous = 1'b1;
      tick(1);
      i = 0;
      while (i < 400 && !(mb.meas && (cyc + 1 - mb.t0) == 37)) begin
         tick(0);
         i++;
      end
      check("p4_reach_37", i < 400, 1);
      clear_stats();
      tick(1);
      check("p4_no_valid_on_restart", pv_b, 0);
      for (int j = 0; j < 250; j++) tick(0);
      check("p4_first_after_restart", first_b, 100);

      // start coincident with a rise while IDLE.
      continuous = 1'b0;
      set_gen(30);
      i = 0;
      while (i < 300 && (mb.armed || mb.meas)) begin
         tick(0);
         i++;
      end
      check("p5_reach_idle", i < 300, 1);
      i = 0;
      while (i < 100 && !(sq[S-1] & ~sq[S])) begin
         tick(0);
         i++;
      end
      check("p5_reach_rise", i < 100, 1);
      clear_stats();
      tick(1);
      check("p5_rise_tick_with_start", rt_b, 1);
      for (int j = 0; j < 100; j++) tick(0);
      check("p5_report_count", vc_b, 1);
      check("p5_period", first_b, 30);

      // Reset mid-measurement, then a fresh single-shot.
      set_gen(60);
      tick(1);
      i = 0;
      while (i < 200 && !mb.meas) begin
         tick(0);
         i++;
      end
      check("p6_reach_measure", i < 200, 1);
      for (int j = 0; j < 20; j++) tick(0);
      reset = 1'b0;
      #1;
      check("p6_async_clear_busy", busy_b, 0);
      for (int j = 0; j < 3; j++) tick(0);
      reset = 1'b1;
      clear_stats();
      for (int j = 0; j < 5; j++) tick(0);
      check("p6_no_stale_valid", vc_b, 0);
      tick(1);
      for (int j = 0; j < 150; j++) tick(0);
      check("p6_report_count", vc_b, 1);
      check("p6_period", last_b, 60);

      // Randomized segments checked cycle by cycle against the model.
      for (int seg = 0; seg < 20; seg++) begin
         if (seg % 2 == 0) gen_per = $urandom_range(2, 15);
         else gen_per = $urandom_range(2, 130);
         if ($urandom_range(0, 1) == 1) gen_ph = 0;
         else gen_ph = gen_ph % gen_per;
         continuous = $urandom_range(0, 1);
         n = $urandom_range(50, 300);
         tick(1);
         for (int j = 0; j < n; j++) tick($urandom_range(0, 39) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
